ws_inst_sequencer: RTL and testbench

//  Upstream instruction generator for the WS core. Replaces bench-driven stimulus:
//  for each of KS*KS kernel positions it emits the 35-bit inst stream to move kernel

---
 rtl/ws_pkg.sv | 36 +++
 rtl/ws_acc_addr_gen.sv | 23 ++
 rtl/ws_inst_sequencer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ws_inst_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ws_pkg.sv
// Shared definitions for the WS-core instruction sequencer.
//   INST_W / ADDR_W : instruction word and memory address widths
//   B_*             : bit positions inside the 35-bit core instruction word
//   IDLE_INST       : word with both memories deselected (CEN=WEN=1), all else 0
//   state_t         : sequencer FSM state encoding
package ws_pkg;

  localparam int INST_W = 35;
  localparam int ADDR_W = 11;

  localparam int B_MODE     = 34;
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LSB   = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LSB   = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  localparam logic [INST_W-1:0] IDLE_INST =
    (INST_W'(1) << B_CEN_P) | (INST_W'(1) << B_WEN_P) |
    (INST_W'(1) << B_CEN_X) | (INST_W'(1) << B_WEN_X);

  typedef enum logic [3:0] {
    S_IDLE, S_CRST, S_W_L0, S_W_LOAD, S_A_L0, S_EXEC, S_DRAIN_WAIT,
    S_DRAIN, S_ACC_RST, S_ACC_RD, S_ACC_OUT, S_DONE
  } state_t;

endpackage

// File: rtl/ws_acc_addr_gen.sv
// Accumulation-pass pmem read address.
//   j      : kernel position index (0..KS*KS-1)
//   oy, ox : output pixel row / column
//   ky, kx : kernel row / column of position j (kept by the parent as counters)
//   addr   : j*NIJ + (oy+ky)*IW + (ox+kx)
module ws_acc_addr_gen
  import ws_pkg::*;
#(
  parameter int IW = 6
) (
  input  logic [ADDR_W-1:0] j,
  input  logic [ADDR_W-1:0] oy,
  input  logic [ADDR_W-1:0] ox,
  input  logic [ADDR_W-1:0] ky,
  input  logic [ADDR_W-1:0] kx,
  output logic [ADDR_W-1:0] addr
);

  localparam int NIJ = IW * IW;

  assign addr = j * ADDR_W'(NIJ) + (oy + ky) * ADDR_W'(IW) + (ox + kx);

endmodule

// File: rtl/ws_inst_sequencer.sv
// Instruction sequencer for the WS core: per kernel position loads weights and
// activations, executes and drains partial sums to pmem, then accumulates every
// output pixel from pmem and strobes out_valid per pixel.
//   clk, reset (async, active low), start (pulse in IDLE), ofifo_valid (core)
//   inst (35-bit core word), core_reset, busy, out_valid, out_idx, done
//
// state        | meaning
// S_IDLE       | waiting for start
// S_CRST       | core reset for RST_CYC cycles, then one idle word
// S_W_L0       | kernel rows xmem -> L0
// S_W_LOAD     | L0 -> PE weight load, then one idle word
// S_A_L0       | activations xmem -> L0, then one idle word
// S_EXEC       | stream activations through the array, then one idle word
// S_DRAIN_WAIT | idle until OFIFO reports a full row
// S_DRAIN      | OFIFO -> pmem for NIJ rows, then one idle word
// S_ACC_RST    | core reset before each output pixel
// S_ACC_RD     | read KS*KS partial sums with accumulate, plus final acc step
// S_ACC_OUT    | idle word, then out_valid for the pixel
// S_DONE       | done pulse, back to idle
module ws_inst_sequencer
  import ws_pkg::*;
#(
  parameter int               ROW     = 8,
  parameter int               COL     = 8,
  parameter int               KS      = 3,
  parameter int               IW      = 6,
  parameter int               OW      = 4,
  parameter logic [ADDR_W-1:0] WBASE  = 11'd1024,
  parameter int               RST_CYC = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        ofifo_valid,
  output logic [INST_W-1:0]           inst,
  output logic                        core_reset,
  output logic                        busy,
  output logic                        out_valid,
  output logic [$clog2(OW*OW)-1:0]    out_idx,
  output logic                        done
);

  localparam int NIJ      = IW * IW;
  localparam int ONIJ     = OW * OW;
  localparam int KK       = KS * KS;
  localparam int EXEC_LEN = NIJ + ROW + COL;
  localparam int CNT_W    = $clog2(EXEC_LEN + RST_CYC + NIJ + COL + KK + 4);
  localparam int KIJ_W    = $clog2(KK + 1);
  localparam int OI_W     = $clog2(ONIJ);
  localparam int OC_W     = $clog2(OW + 1);
  localparam int KC_W     = $clog2(KS + 1);

  if (KK * NIJ > 1024) begin : g_pmem_range
    $error("ws_inst_sequencer: KS*KS*NIJ exceeds 1024 pmem words");
  end
  if (int'(WBASE) + KK * COL > 2048) begin : g_xmem_range
    $error("ws_inst_sequencer: kernel region exceeds 11-bit xmem space");
  end
  if (OW != IW - KS + 1) begin : g_ow_check
    $error("ws_inst_sequencer: OW must equal IW-KS+1");
  end

  state_t             state, nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [KIJ_W-1:0]   kij, kij_nxt;
  logic [OI_W-1:0]    o_idx, o_nxt;
  logic [OC_W-1:0]    oy, ox, oy_nxt, ox_nxt;
  logic [KC_W-1:0]    ky, kx, ky_nxt, kx_nxt;
  logic [INST_W-1:0]  inst_d;
  logic               core_reset_d, busy_d, out_valid_d, done_d;
  logic [ADDR_W-1:0]  w_addr, p_addr, acc_addr;

  assign w_addr = WBASE + ADDR_W'(kij) * ADDR_W'(COL) + ADDR_W'(cnt);
  // drain writes start one cycle after the first ofifo_rd, hence cnt-1
  assign p_addr = ADDR_W'(kij) * ADDR_W'(NIJ) + ADDR_W'(cnt) - ADDR_W'(1);

  ws_acc_addr_gen #(.IW(IW)) u_acc_addr (
    .j    (ADDR_W'(cnt)),
    .oy   (ADDR_W'(oy)),
    .ox   (ADDR_W'(ox)),
    .ky   (ADDR_W'(ky)),
    .kx   (ADDR_W'(kx)),
    .addr (acc_addr)
  );

  always_comb begin
    nxt          = state;
    cnt_nxt      = cnt + CNT_W'(1);
    kij_nxt      = kij;
    o_nxt        = o_idx;
    oy_nxt       = oy;
    ox_nxt       = ox;
    ky_nxt       = ky;
    kx_nxt       = kx;
    inst_d       = IDLE_INST;
    core_reset_d = 1'b0;
    out_valid_d  = 1'b0;
    done_d       = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          nxt     = S_CRST;
          kij_nxt = '0;
        end
      end
      S_CRST: begin
        if (cnt == CNT_W'(RST_CYC)) begin
          nxt     = S_W_L0;
          cnt_nxt = '0;
        end else begin
          core_reset_d = 1'b1;
        end
      end
      S_W_L0: begin
        inst_d[B_CEN_X]              = 1'b0;
        inst_d[B_L0_WR]              = 1'b1;
        inst_d[B_AX_LSB +: ADDR_W]   = w_addr;
        if (cnt == CNT_W'(COL - 1)) begin
          nxt     = S_W_LOAD;
          cnt_nxt = '0;
        end
      end
      S_W_LOAD: begin
        if (cnt == CNT_W'(COL + 1)) begin
          nxt     = S_A_L0;
          cnt_nxt = '0;
        end else begin
          inst_d[B_L0_RD] = 1'b1;
          inst_d[B_LOAD]  = (cnt != '0);
        end
      end
      S_A_L0: begin
        if (cnt == CNT_W'(NIJ)) begin
          nxt     = S_EXEC;
          cnt_nxt = '0;
        end else begin
          inst_d[B_CEN_X]            = 1'b0;
          inst_d[B_L0_WR]            = 1'b1;
          inst_d[B_AX_LSB +: ADDR_W] = ADDR_W'(cnt);
        end
      end
      S_EXEC: begin
        if (cnt == CNT_W'(EXEC_LEN + 1)) begin
          nxt     = S_DRAIN_WAIT;
          cnt_nxt = '0;
        end else begin
          inst_d[B_L0_RD] = 1'b1;
          inst_d[B_EXEC]  = (cnt != '0);
        end
      end
      S_DRAIN_WAIT: begin
        cnt_nxt = '0;
        if (ofifo_valid) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt == CNT_W'(NIJ + 1)) begin
          cnt_nxt = '0;
          if (kij == KIJ_W'(KK - 1)) begin
            nxt    = S_ACC_RST;
            o_nxt  = '0;
            oy_nxt = '0;
            ox_nxt = '0;
          end else begin
            nxt     = S_CRST;
            kij_nxt = kij + KIJ_W'(1);
          end
        end else begin
          inst_d[B_OFIFO_RD] = 1'b1;
          if (cnt != '0) begin
            inst_d[B_CEN_P]            = 1'b0;
            inst_d[B_WEN_P]            = 1'b0;
            inst_d[B_AP_LSB +: ADDR_W] = p_addr;
          end
        end
      end
      S_ACC_RST: begin
        core_reset_d = 1'b1;
        nxt          = S_ACC_RD;
        cnt_nxt      = '0;
        ky_nxt       = '0;
        kx_nxt       = '0;
      end
      S_ACC_RD: begin
        inst_d[B_ACC] = (cnt != '0);
        if (cnt == CNT_W'(KK)) begin
          nxt     = S_ACC_OUT;
          cnt_nxt = '0;
        end else begin
          inst_d[B_CEN_P]            = 1'b0;
          inst_d[B_AP_LSB +: ADDR_W] = acc_addr;
          if (kx == KC_W'(KS - 1)) begin
            kx_nxt = '0;
            ky_nxt = ky + KC_W'(1);
          end else begin
            kx_nxt = kx + KC_W'(1);
          end
        end
      end
      S_ACC_OUT: begin
        if (cnt != '0) begin
          out_valid_d = 1'b1;
          cnt_nxt     = '0;
          if (o_idx == OI_W'(ONIJ - 1)) begin
            nxt = S_DONE;
          end else begin
            nxt   = S_ACC_RST;
            o_nxt = o_idx + OI_W'(1);
            if (ox == OC_W'(OW - 1)) begin
              ox_nxt = '0;
              oy_nxt = oy + OC_W'(1);
            end else begin
              ox_nxt = ox + OC_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        nxt     = S_IDLE;
        cnt_nxt = '0;
      end
      default: begin
        nxt     = S_IDLE;
        cnt_nxt = '0;
      end
    endcase
    // busy follows the next state so it rises right after start and drops with done
    busy_d = (nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      kij        <= '0;
      o_idx      <= '0;
      oy         <= '0;
      ox         <= '0;
      ky         <= '0;
      kx         <= '0;
      inst       <= IDLE_INST;
      core_reset <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      out_idx    <= '0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_nxt;
      kij        <= kij_nxt;
      o_idx      <= o_nxt;
      oy         <= oy_nxt;
      ox         <= ox_nxt;
      ky         <= ky_nxt;
      kx         <= kx_nxt;
      inst       <= inst_d;
      core_reset <= core_reset_d;
      busy       <= busy_d;
      out_valid  <= out_valid_d;
      done       <= done_d;
      if (out_valid_d) out_idx <= o_idx;
    end
  end

endmodule

// File: tb/tb_ws_inst_sequencer.sv
// Scoreboard bench for ws_inst_sequencer: the stimulus process pushes expected
// xmem/pmem addresses, run lengths, pixel indices and output snapshots; the
// monitor process pops and compares whenever the DUT presents the matching word.
module tb_ws_inst_sequencer;

  localparam logic [34:0] IDLE_WORD = 35'h1_800C_0000;
  localparam int NIJ = 36;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [34:0] inst;
  logic        core_reset, busy, out_valid, done;
  logic [3:0]  out_idx;

  ws_inst_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .core_reset  (core_reset),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [34:0] inst;
    logic        busy;
    logic        core_reset;
    logic        out_valid;
    logic        done;
    logic [3:0]  out_idx;
  } snap_t;

  snap_t q_snap[$];
  int    q_xrd[$], q_pwr[$], q_prd[$], q_oidx[$];
  int    q_exec[$], q_load[$], q_acc[$], q_crst[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit final_req = 1'b0;
  bit final_ack = 1'b0;
  bit timeout = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int exec_run = 0, load_run = 0, acc_run = 0, crst_run = 0, done_cnt = 0;
  bit prev_ov = 1'b0;

  always @(negedge clk) begin
    if (q_snap.size() != 0) begin
      snap_t s;
      s = q_snap.pop_front();
      chk("snap_inst", inst, s.inst);
      chk("snap_busy", busy, s.busy);
      chk("snap_core_reset", core_reset, s.core_reset);
      chk("snap_out_valid", out_valid, s.out_valid);
      chk("snap_done", done, s.done);
      chk("snap_out_idx", out_idx, s.out_idx);
    end
    if (!mon_en) begin
      exec_run = 0; load_run = 0; acc_run = 0; crst_run = 0; prev_ov = 1'b0;
    end else begin
      if (!inst[19]) begin
        if (q_xrd.size() == 0) chk("xmem_rd_unexpected", inst[17:7], -1);
        else chk("xmem_rd_addr", {inst[18], inst[2], inst[17:7]}, (3 << 11) | q_xrd.pop_front());
      end
      if (!inst[32] && !inst[31]) begin
        if (q_pwr.size() == 0) chk("pmem_wr_unexpected", inst[30:20], -1);
        else chk("pmem_wr_addr", {inst[6], inst[30:20]}, (1 << 11) | q_pwr.pop_front());
      end
      if (!inst[32] && inst[31]) begin
        if (q_prd.size() == 0) chk("pmem_rd_unexpected", inst[30:20], -1);
        else chk("pmem_rd_addr", inst[30:20], q_prd.pop_front());
      end
      if (inst[1]) exec_run++;
      else if (exec_run != 0) begin
        chk("exec_len", exec_run, (q_exec.size() != 0) ? q_exec.pop_front() : 0);
        exec_run = 0;
      end
      if (inst[0]) load_run++;
      else if (load_run != 0) begin
        chk("load_len", load_run, (q_load.size() != 0) ? q_load.pop_front() : 0);
        load_run = 0;
      end
      if (inst[33]) acc_run++;
      else if (acc_run != 0) begin
        chk("acc_len", acc_run, (q_acc.size() != 0) ? q_acc.pop_front() : 0);
        acc_run = 0;
      end
      if (core_reset) crst_run++;
      else if (crst_run != 0) begin
        chk("core_reset_len", crst_run, (q_crst.size() != 0) ? q_crst.pop_front() : 0);
        crst_run = 0;
      end
      if (out_valid) begin
        chk("out_idx", out_idx, (q_oidx.size() != 0) ? q_oidx.pop_front() : -1);
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last_pixel", {prev_ov, out_idx}, {1'b1, 4'd15});
      end
      prev_ov = out_valid;
    end
    if (final_req && !final_ack) begin
      chk("xmem_rd_left", q_xrd.size(), 0);
      chk("pmem_wr_left", q_pwr.size(), 0);
      chk("pmem_rd_left", q_prd.size(), 0);
      chk("out_valid_left", q_oidx.size(), 0);
      chk("exec_runs_left", q_exec.size(), 0);
      chk("load_runs_left", q_load.size(), 0);
      chk("acc_runs_left", q_acc.size(), 0);
      chk("core_reset_runs_left", q_crst.size(), 0);
      chk("done_count", done_cnt, 1);
      chk("wait_timeout", timeout, 0);
      final_ack = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_snap(input logic [34:0] i, input logic b, input logic cr,
                           input logic ov, input logic dn, input logic [3:0] oi);
    snap_t s;
    s.inst = i; s.busy = b; s.core_reset = cr; s.out_valid = ov; s.done = dn; s.out_idx = oi;
    q_snap.push_back(s);
  endtask

  task automatic wait_exec(input logic lvl);
    int n = 0;
    while (inst[1] !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) timeout = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // hand-derived reads for pixel o=5 (oy=1, ox=1)
  int acc_o5[9] = '{7, 44, 81, 121, 158, 195, 235, 272, 309};

  initial begin
    reset = 1'b0; start = 1'b0; ofifo_valid = 1'b1;
    #1 push_snap(IDLE_WORD, 0, 0, 0, 0, 4'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    // abort a run mid-EXEC with an async reset
    pulse_start();
    wait_exec(1'b1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    push_snap(IDLE_WORD, 0, 0, 0, 0, 4'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);

    // expectations for a full layer
    for (int k = 0; k < 9; k++) begin
      q_crst.push_back(10);
      q_load.push_back(8);
      q_exec.push_back(52);
      for (int i = 0; i < 8; i++) q_xrd.push_back(1024 + 8 * k + i);  // kij0 1024.., kij4 1056..
      for (int i = 0; i < NIJ; i++) q_xrd.push_back(i);
      for (int i = 0; i < NIJ; i++) q_pwr.push_back(NIJ * k + i);    // kij4 144..179
    end
    for (int o = 0; o < 16; o++) begin
      q_crst.push_back(1);
      q_acc.push_back(9);
      q_oidx.push_back(o);
      for (int j = 0; j < 9; j++) begin
        if (o == 5) q_prd.push_back(acc_o5[j]);
        else q_prd.push_back(j * NIJ + ((o / 4) + (j / 3)) * 6 + ((o % 4) + (j % 3)));
      end
    end
    @(posedge clk); #1 mon_en = 1'b1;
    pulse_start();

    wait_exec(1'b1);
    wait_exec(1'b0);
    pulse_start();          // must be ignored while busy
    wait_exec(1'b1);
    wait_exec(1'b0);
    wait_exec(1'b1);        // kij2 executing
    ofifo_valid = 1'b0;     // low before drain must not matter, then stall the drain
    wait_exec(1'b0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1 push_snap(IDLE_WORD, 1, 0, 0, 0, 4'd0);
    end
    ofifo_valid = 1'b1;

    begin
      int n = 0;
      while (done !== 1'b1 && n < 8000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 8000) timeout = 1'b1;
    end
    @(posedge clk); #1 push_snap(IDLE_WORD, 0, 0, 0, 0, 4'd15);
    repeat (2) @(negedge clk);
    #1 final_req = 1'b1;
    begin
      int n = 0;
      while (!final_ack && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
